// File: rtl/dlsc_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dlsc_cmd_pkg
// Purpose  : Shared response codes, FSM state encoding and sizing helper.
// Revision : 1.0
// ============================================================================
package dlsc_cmd_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;
    localparam logic [1:0] RESP_DECERR = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CMD  = 3'd1,
        ST_RESP = 3'd2,
        ST_ERR  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // Index width that never collapses to zero bits.
    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dlsc_address_decoder.sv
`default_nettype none
// ============================================================================
// Module   : dlsc_address_decoder
// Purpose  : Masked base-address match; lowest matching range index wins.
// Revision : 1.0
// ============================================================================
module dlsc_address_decoder
    import dlsc_cmd_pkg::*;
#(
    parameter int                      ADDR    = 32,
    parameter int                      RANGES  = 4,
    parameter int                      RANGESB = 2,
    parameter logic [RANGES*ADDR-1:0]  MASKS   = '0,
    parameter logic [RANGES*ADDR-1:0]  BASES   = '0
) (
    input  logic [ADDR-1:0]    addr_i,
    output logic               match_valid_o,
    output logic [RANGESB-1:0] match_o
);

    // Scan from the top so the lowest-index match is written last.
    always_comb begin
        match_valid_o = 1'b0;
        match_o       = '0;
        for (int i = RANGES - 1; i >= 0; i--) begin
            if ((addr_i & ~MASKS[i*ADDR +: ADDR]) ==
                (BASES[i*ADDR +: ADDR] & ~MASKS[i*ADDR +: ADDR])) begin
                match_valid_o = 1'b1;
                match_o       = RANGESB'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dlsc_cmd_arbiter_decode.sv
`default_nettype none
// ============================================================================
// Module   : dlsc_cmd_arbiter_decode
// Purpose  : Round-robin command arbiter with address decode, response return,
//            internal DECERR/SLVERR generation. One command in flight.
// Revision : 1.0
// ============================================================================
module dlsc_cmd_arbiter_decode
    import dlsc_cmd_pkg::*;
#(
    parameter int                      ADDR    = 32,
    parameter int                      DATA    = 32,
    parameter int                      MASTERS = 2,
    parameter int                      SLAVES  = 4,
    parameter int                      SLAVESB = 2,
    parameter logic [SLAVES*ADDR-1:0]  MASKS   = '0,
    parameter logic [SLAVES*ADDR-1:0]  BASES   = '0,
    parameter int                      TIMEOUT = 256
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic [MASTERS-1:0]        in_valid_i,
    output logic [MASTERS-1:0]        in_ready_o,
    input  logic [MASTERS*ADDR-1:0]   in_addr_i,
    input  logic [MASTERS-1:0]        in_write_i,
    input  logic [MASTERS*DATA-1:0]   in_wdata_i,
    output logic [MASTERS-1:0]        in_rvalid_o,
    output logic [DATA-1:0]           in_rdata_o,
    output logic [1:0]                in_rresp_o,

    output logic [SLAVES-1:0]         out_valid_o,
    input  logic [SLAVES-1:0]         out_ready_i,
    output logic [ADDR-1:0]           out_addr_o,
    output logic                      out_write_o,
    output logic [DATA-1:0]           out_wdata_o,
    input  logic [SLAVES-1:0]         out_rvalid_i,
    input  logic [SLAVES*DATA-1:0]    out_rdata_i,
    input  logic [SLAVES*2-1:0]       out_rresp_i
);

    localparam int c_MB = clog2_min1(MASTERS);
    localparam int c_TW = clog2_min1(TIMEOUT + 1);
    localparam logic [c_TW-1:0] c_TLAST = c_TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t            state_q, state_d;
    logic [c_MB-1:0]   last_grant_q, last_grant_d;
    logic [c_MB-1:0]   owner_q, owner_d;
    logic [SLAVESB-1:0] sel_q, sel_d;
    logic [ADDR-1:0]   addr_q, addr_d;
    logic              write_q, write_d;
    logic [DATA-1:0]   wdata_q, wdata_d;
    logic [DATA-1:0]   rdata_q, rdata_d;
    logic [1:0]        rresp_q, rresp_d;
    logic [c_TW-1:0]   tcnt_q, tcnt_d;

    logic              w_any;
    logic [c_MB-1:0]   w_winner;
    int                w_idx;
    logic [ADDR-1:0]   w_addr;
    logic              w_match_valid;
    logic [SLAVESB-1:0] w_match;

    // Round-robin: first requester after last_grant, wrapping.
    always_comb begin
        w_any    = 1'b0;
        w_winner = last_grant_q;
        w_idx    = 0;
        for (int i = 1; i <= MASTERS; i++) begin
            w_idx = int'(last_grant_q) + i;
            if (w_idx >= MASTERS) begin
                w_idx = w_idx - MASTERS;
            end
            if (!w_any && in_valid_i[c_MB'(w_idx)]) begin
                w_any    = 1'b1;
                w_winner = c_MB'(w_idx);
            end
        end
    end

    assign w_addr = in_addr_i[w_winner*ADDR +: ADDR];

    dlsc_address_decoder #(
        .ADDR    (ADDR),
        .RANGES  (SLAVES),
        .RANGESB (SLAVESB),
        .MASKS   (MASKS),
        .BASES   (BASES)
    ) u_decoder (
        .addr_i        (w_addr),
        .match_valid_o (w_match_valid),
        .match_o       (w_match)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        sel_d        = sel_q;
        addr_d       = addr_q;
        write_d      = write_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        rresp_d      = rresp_q;
        tcnt_d       = tcnt_q;
        in_ready_o   = '0;
        in_rvalid_o  = '0;
        out_valid_o  = '0;

        case (state_q)
            ST_IDLE: begin
                if (w_any) begin
                    in_ready_o[w_winner] = 1'b1;
                    owner_d      = w_winner;
                    last_grant_d = w_winner;
                    addr_d       = w_addr;
                    write_d      = in_write_i[w_winner];
                    wdata_d      = in_wdata_i[w_winner*DATA +: DATA];
                    sel_d        = w_match;
                    state_d      = w_match_valid ? ST_CMD : ST_ERR;
                end
            end
            ST_CMD: begin
                out_valid_o[sel_q] = 1'b1;
                if (out_ready_i[sel_q]) begin
                    tcnt_d  = '0;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                // A response on the expiry cycle wins over the timeout.
                if (out_rvalid_i[sel_q]) begin
                    rdata_d = out_rdata_i[sel_q*DATA +: DATA];
                    rresp_d = out_rresp_i[sel_q*2 +: 2];
                    state_d = ST_DONE;
                end else if ((TIMEOUT != 0) && (tcnt_q == c_TLAST)) begin
                    rdata_d = '0;
                    rresp_d = RESP_SLVERR;
                    state_d = ST_DONE;
                end else if (tcnt_q != '1) begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            ST_ERR: begin
                rdata_d = '0;
                rresp_d = RESP_DECERR;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                in_rvalid_o[owner_q] = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= c_MB'(MASTERS - 1);
            owner_q      <= '0;
            sel_q        <= '0;
            addr_q       <= '0;
            write_q      <= 1'b0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            rresp_q      <= RESP_OKAY;
            tcnt_q       <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            sel_q        <= sel_d;
            addr_q       <= addr_d;
            write_q      <= write_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            rresp_q      <= rresp_d;
            tcnt_q       <= tcnt_d;
        end
    end

    assign out_addr_o  = addr_q;
    assign out_write_o = write_q;
    assign out_wdata_o = wdata_q;
    assign in_rdata_o  = rdata_q;
    assign in_rresp_o  = rresp_q;

endmodule
`default_nettype wire

// File: tb/tb_dlsc_cmd_arbiter_decode.sv
`default_nettype none
// ============================================================================
// Module   : tb_dlsc_cmd_arbiter_decode
// Purpose  : Directed self-checking bench for dlsc_cmd_arbiter_decode.
// Revision : 1.0
// ============================================================================
module tb_dlsc_cmd_arbiter_decode;

    localparam int MASTERS = 2;
    localparam int SLAVES  = 4;
    // slave0: 0x2000-0x20FF, slave1: 0x1xxx, slave2: 0x2xxx, slave3: 0x3xxx
    localparam logic [SLAVES*32-1:0] MASKS = {32'h0000_0FFF, 32'h0000_0FFF, 32'h0000_0FFF, 32'h0000_00FF};
    localparam logic [SLAVES*32-1:0] BASES = {32'h0000_3000, 32'h0000_2000, 32'h0000_1000, 32'h0000_2000};

    logic                   clk;
    logic                   rst;
    logic [MASTERS-1:0]     in_valid;
    logic [MASTERS-1:0]     in_ready;
    logic [MASTERS*32-1:0]  in_addr;
    logic [MASTERS-1:0]     in_write;
    logic [MASTERS*32-1:0]  in_wdata;
    logic [MASTERS-1:0]     in_rvalid;
    logic [31:0]            in_rdata;
    logic [1:0]             in_rresp;
    logic [SLAVES-1:0]      out_valid;
    logic [SLAVES-1:0]      out_ready;
    logic [31:0]            out_addr;
    logic                   out_write;
    logic [31:0]            out_wdata;
    logic [SLAVES-1:0]      out_rvalid;
    logic [SLAVES*32-1:0]   out_rdata;
    logic [SLAVES*2-1:0]    out_rresp;

    int total = 0;
    int bad   = 0;

    dlsc_cmd_arbiter_decode #(
        .ADDR    (32),
        .DATA    (32),
        .MASTERS (MASTERS),
        .SLAVES  (SLAVES),
        .SLAVESB (2),
        .MASKS   (MASKS),
        .BASES   (BASES),
        .TIMEOUT (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .in_addr_i    (in_addr),
        .in_write_i   (in_write),
        .in_wdata_i   (in_wdata),
        .in_rvalid_o  (in_rvalid),
        .in_rdata_o   (in_rdata),
        .in_rresp_o   (in_rresp),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_addr_o   (out_addr),
        .out_write_o  (out_write),
        .out_wdata_o  (out_wdata),
        .out_rvalid_i (out_rvalid),
        .out_rdata_i  (out_rdata),
        .out_rresp_i  (out_rresp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic step;
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = '0; in_addr = '0; in_write = '0; in_wdata = '0;
        out_ready = '0; out_rvalid = '0; out_rdata = '0; out_rresp = '0;
        step; step;
        #1;
        total++; if (in_ready !== 2'b00) begin bad++; $display("FAIL reset_in_ready got=%b want=00", in_ready); end
        total++; if (in_rvalid !== 2'b00) begin bad++; $display("FAIL reset_in_rvalid got=%b want=00", in_rvalid); end
        total++; if (out_valid !== 4'b0000) begin bad++; $display("FAIL reset_out_valid got=%b want=0000", out_valid); end
        total++; if (out_addr !== 32'h0) begin bad++; $display("FAIL reset_out_addr got=%h want=0", out_addr); end
        total++; if (in_rdata !== 32'h0 || in_rresp !== 2'd0) begin bad++; $display("FAIL reset_resp got=%h/%0d want=0/0", in_rdata, in_rresp); end
        rst = 1'b0;
    endtask

    task automatic test_fairness;
        logic [1:0]  exp_g [6];
        logic [31:0] exp_a;
        exp_g = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
        in_addr[0 +: 32] = 32'h0000_3000;
        in_addr[32 +: 32] = 32'h0000_3004;
        in_write = 2'b00;
        in_valid = 2'b11;
        for (int i = 0; i < 6; i++) begin
            exp_a = (exp_g[i] == 2'b01) ? 32'h0000_3000 : 32'h0000_3004;
            #1;
            total++; if (in_ready !== exp_g[i]) begin bad++; $display("FAIL fair_grant%0d got=%b want=%b", i, in_ready, exp_g[i]); end
            step;
            #1;
            total++; if (in_ready !== 2'b00) begin bad++; $display("FAIL fair_noready_cmd%0d got=%b want=00", i, in_ready); end
            total++; if (out_valid !== 4'b1000) begin bad++; $display("FAIL fair_out_valid%0d got=%b want=1000", i, out_valid); end
            total++; if (out_addr !== exp_a) begin bad++; $display("FAIL fair_out_addr%0d got=%h want=%h", i, out_addr, exp_a); end
            out_ready = 4'b1000;
            step;
            out_ready = 4'b0000;
            out_rvalid = 4'b1000;
            out_rdata[96 +: 32] = 32'h0000_0100 + i;
            out_rresp[6 +: 2] = 2'd1;
            step;
            out_rvalid = 4'b0000;
            #1;
            total++; if (in_rvalid !== exp_g[i]) begin bad++; $display("FAIL fair_rvalid%0d got=%b want=%b", i, in_rvalid, exp_g[i]); end
            total++; if (in_rdata !== 32'h0000_0100 + i || in_rresp !== 2'd1) begin bad++; $display("FAIL fair_rdata%0d got=%h/%0d want=%h/1", i, in_rdata, in_rresp, 32'h0000_0100 + i); end
            step;
        end
        in_valid = 2'b00;
    endtask

    task automatic test_single_read;
        in_addr[0 +: 32] = 32'h0000_1004;
        in_write[0] = 1'b0;
        in_valid = 2'b01;
        #1;
        total++; if (in_ready !== 2'b01) begin bad++; $display("FAIL read_ready got=%b want=01", in_ready); end
        step;
        in_valid = 2'b00;
        #1;
        total++; if (out_valid !== 4'b0010) begin bad++; $display("FAIL read_out_valid got=%b want=0010", out_valid); end
        total++; if (out_addr !== 32'h0000_1004 || out_write !== 1'b0) begin bad++; $display("FAIL read_out_addr got=%h/%b want=00001004/0", out_addr, out_write); end
        out_ready = 4'b0010;
        step;
        out_ready = 4'b0000;
        #1;
        total++; if (out_valid !== 4'b0000) begin bad++; $display("FAIL read_valid_drop got=%b want=0000", out_valid); end
        step;
        #1;
        total++; if (in_rvalid !== 2'b00) begin bad++; $display("FAIL read_early_rvalid got=%b want=00", in_rvalid); end
        out_rvalid = 4'b0010;
        out_rdata[32 +: 32] = 32'hDEAD_BEEF;
        out_rresp[2 +: 2] = 2'd0;
        step;
        out_rvalid = 4'b0000;
        #1;
        total++; if (in_rvalid !== 2'b01) begin bad++; $display("FAIL read_rvalid got=%b want=01", in_rvalid); end
        total++; if (in_rdata !== 32'hDEAD_BEEF || in_rresp !== 2'd0) begin bad++; $display("FAIL read_rdata got=%h/%0d want=deadbeef/0", in_rdata, in_rresp); end
        step;
        #1;
        total++; if (in_rvalid !== 2'b00) begin bad++; $display("FAIL read_rvalid_once got=%b want=00", in_rvalid); end
        total++; if (in_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL read_rdata_hold got=%h want=deadbeef", in_rdata); end
    endtask

    task automatic test_decerr;
        in_addr[32 +: 32] = 32'hFFFF_0000;
        in_write[1] = 1'b1;
        in_wdata[32 +: 32] = 32'hA5A5_0001;
        in_valid = 2'b10;
        #1;
        total++; if (in_ready !== 2'b10) begin bad++; $display("FAIL dec_ready got=%b want=10", in_ready); end
        step;
        in_valid = 2'b00;
        #1;
        total++; if (out_valid !== 4'b0000 || in_rvalid !== 2'b00) begin bad++; $display("FAIL dec_quiet got=%b/%b want=0000/00", out_valid, in_rvalid); end
        total++; if (out_addr !== 32'hFFFF_0000 || out_write !== 1'b1 || out_wdata !== 32'hA5A5_0001) begin bad++; $display("FAIL dec_capture got=%h/%b/%h want=ffff0000/1/a5a50001", out_addr, out_write, out_wdata); end
        step;
        #1;
        total++; if (in_rvalid !== 2'b10) begin bad++; $display("FAIL dec_rvalid got=%b want=10", in_rvalid); end
        total++; if (in_rresp !== 2'd3 || in_rdata !== 32'h0) begin bad++; $display("FAIL dec_resp got=%h/%0d want=0/3", in_rdata, in_rresp); end
        step;
        #1;
        total++; if (in_rvalid !== 2'b00) begin bad++; $display("FAIL dec_rvalid_once got=%b want=00", in_rvalid); end
    endtask

    task automatic test_overlap;
        in_addr[0 +: 32] = 32'h0000_2000;
        in_write[0] = 1'b0;
        in_valid = 2'b01;
        step;
        in_valid = 2'b00;
        #1;
        total++; if (out_valid !== 4'b0001) begin bad++; $display("FAIL ovl_out_valid got=%b want=0001", out_valid); end
        out_ready = 4'b0101;
        step;
        out_ready = 4'b0000;
        out_rvalid = 4'b0100;
        out_rdata[64 +: 32] = 32'h0BAD_0BAD;
        step;
        #1;
        total++; if (in_rvalid !== 2'b00) begin bad++; $display("FAIL ovl_ignore_other got=%b want=00", in_rvalid); end
        out_rvalid = 4'b0001;
        out_rdata[0 +: 32] = 32'h0000_0055;
        out_rresp[0 +: 2] = 2'd0;
        step;
        out_rvalid = 4'b0000;
        #1;
        total++; if (in_rvalid !== 2'b01 || in_rdata !== 32'h0000_0055) begin bad++; $display("FAIL ovl_resp got=%b/%h want=01/00000055", in_rvalid, in_rdata); end
        step;
    endtask

    task automatic test_timeout(input logic late_resp);
        in_addr[0 +: 32] = 32'h0000_1008;
        in_write[0] = 1'b0;
        in_valid = 2'b01;
        step;
        in_valid = 2'b00;
        out_ready = 4'b0010;
        out_rdata[32 +: 32] = 32'h7777_7777;
        step;
        out_ready = 4'b0000;
        for (int n = 1; n <= 8; n++) begin
            #1;
            total++; if (in_rvalid !== 2'b00) begin bad++; $display("FAIL to_wait%0d got=%b want=00", n, in_rvalid); end
            if (late_resp && n == 8) begin
                out_rvalid = 4'b0010;
                out_rdata[32 +: 32] = 32'hCAFE_0008;
                out_rresp[2 +: 2] = 2'd0;
            end
            step;
            out_rvalid = 4'b0000;
        end
        #1;
        total++; if (in_rvalid !== 2'b01) begin bad++; $display("FAIL to_rvalid got=%b want=01", in_rvalid); end
        if (late_resp) begin
            total++; if (in_rresp !== 2'd0 || in_rdata !== 32'hCAFE_0008) begin bad++; $display("FAIL to_late_ok got=%h/%0d want=cafe0008/0", in_rdata, in_rresp); end
        end else begin
            total++; if (in_rresp !== 2'd2 || in_rdata !== 32'h0) begin bad++; $display("FAIL to_slverr got=%h/%0d want=0/2", in_rdata, in_rresp); end
        end
        step;
    endtask

    task automatic test_reset_midop;
        in_addr[32 +: 32] = 32'h0000_1010;
        in_write[1] = 1'b0;
        in_valid = 2'b10;
        step;
        in_valid = 2'b00;
        out_ready = 4'b0010;
        step;
        out_ready = 4'b0000;
        rst = 1'b1;
        step;
        #1;
        total++; if (in_ready !== 2'b00 || in_rvalid !== 2'b00 || out_valid !== 4'b0000) begin bad++; $display("FAIL rstmid_strobes got=%b/%b/%b want=00/00/0000", in_ready, in_rvalid, out_valid); end
        total++; if (out_addr !== 32'h0 || out_write !== 1'b0 || out_wdata !== 32'h0) begin bad++; $display("FAIL rstmid_cmd got=%h/%b/%h want=0/0/0", out_addr, out_write, out_wdata); end
        total++; if (in_rdata !== 32'h0 || in_rresp !== 2'd0) begin bad++; $display("FAIL rstmid_resp got=%h/%0d want=0/0", in_rdata, in_rresp); end
        rst = 1'b0;
        out_rvalid = 4'b0010;
        step;
        out_rvalid = 4'b0000;
        #1;
        total++; if (in_rvalid !== 2'b00) begin bad++; $display("FAIL rstmid_stale got=%b want=00", in_rvalid); end
        step;
        #1;
        total++; if (in_rvalid !== 2'b00) begin bad++; $display("FAIL rstmid_silent got=%b want=00", in_rvalid); end
        in_valid = 2'b11;
        #1;
        total++; if (in_ready !== 2'b01) begin bad++; $display("FAIL rstmid_first_grant got=%b want=01", in_ready); end
        step;
        in_valid = 2'b00;
        #1;
        total++; if (out_valid !== 4'b0010 || out_addr !== 32'h0000_1008) begin bad++; $display("FAIL rstmid_cmd_out got=%b/%h want=0010/00001008", out_valid, out_addr); end
    endtask

    initial begin
        test_reset();
        test_fairness();
        test_single_read();
        test_decerr();
        test_overlap();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_reset_midop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
